cla_pipe_addsub: RTL and testbench

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pipe_addsub.sv | 170 +++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
//   handshaking on both sides.
//   Stage 1 registers the operands (b already conditionally inverted), the
//   per-bit propagate/generate terms and the per-group (BLK-bit)
//   generate/propagate terms.
//   Stage 2 resolves the group carries with a second lookahead level, then
//   expands them into bit carries inside each group and registers
//   sum/cout/ovf/zero.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : a/b/cin/sub valid this cycle
//   in_ready  : input beat is accepted this cycle
//   a, b      : N-bit operands
//   cin       : carry-in (add mode only)
//   sub       : 0 = add, 1 = subtract (a + ~b + 1)
//   out_valid : result valid
//   out_ready : downstream accepts the result
//   sum       : N-bit result
//   cout      : carry out of bit N-1 (subtract: 1 = no borrow)
//   ovf       : two's-complement signed overflow
//   zero      : sum is all zeros
module cla_pipe_addsub #(
    parameter int unsigned N   = 32,
    parameter int unsigned BLK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned NG = N / BLK;

    // Handshake: a stage advances when empty or when its content leaves.
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- Stage 1 combinational ----------------
    logic [N-1:0]  b_eff;
    logic          cin_eff;
    logic [N-1:0]  p_in;
    logic [N-1:0]  g_in;
    logic [NG-1:0] grp_g_in;
    logic [NG-1:0] grp_p_in;

    always_comb begin
        logic gen;
        logic prop;
        b_eff    = sub ? ~b : b;
        // subtract forces the +1 of two's-complement negation
        cin_eff  = sub | cin;
        p_in     = a ^ b_eff;
        g_in     = a & b_eff;
        grp_g_in = '0;
        grp_p_in = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            gen  = 1'b0;
            prop = 1'b1;
            for (int unsigned j = 0; j < BLK; j++) begin
                gen  = g_in[k*BLK + j] | (p_in[k*BLK + j] & gen);
                prop = prop & p_in[k*BLK + j];
            end
            grp_g_in[k] = gen;
            grp_p_in[k] = prop;
        end
    end

    // ---------------- Stage 1 registers ----------------
    logic [N-1:0]  s1_a;
    logic [N-1:0]  s1_b;
    logic [N-1:0]  s1_p;
    logic [N-1:0]  s1_g;
    logic [NG-1:0] s1_grp_g;
    logic [NG-1:0] s1_grp_p;
    logic          s1_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_grp_g <= '0;
            s1_grp_p <= '0;
            s1_cin   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= a;
                s1_b     <= b_eff;
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_grp_g <= grp_g_in;
                s1_grp_p <= grp_p_in;
                s1_cin   <= cin_eff;
            end
        end
    end

    // ---------------- Stage 2 combinational ----------------
    logic [NG-1:0] grp_cin;
    logic [N-1:0]  bit_cin;
    logic          cout_nxt;
    logic [N-1:0]  sum_nxt;
    logic          ovf_nxt;
    logic          zero_nxt;

    always_comb begin
        logic c;
        // Group-level lookahead: carry into group k from group G/P terms.
        c       = s1_cin;
        grp_cin = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            grp_cin[k] = c;
            c = s1_grp_g[k] | (s1_grp_p[k] & c);
        end
        cout_nxt = c;
        // Expand each group's carry-in into per-bit carries.
        bit_cin = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            c = grp_cin[k];
            for (int unsigned j = 0; j < BLK; j++) begin
                bit_cin[k*BLK + j] = c;
                c = s1_g[k*BLK + j] | (s1_p[k*BLK + j] & c);
            end
        end
        sum_nxt  = s1_a ^ s1_b ^ bit_cin;
        ovf_nxt  = (s1_a[N-1] == s1_b[N-1]) && (sum_nxt[N-1] != s1_a[N-1]);
        zero_nxt = ~|sum_nxt;
    end

    // ---------------- Stage 2 registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_nxt;
                cout <= cout_nxt;
                ovf  <= ovf_nxt;
                zero <= zero_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;

    logic [31:0] a, b, sum;
    logic        in_ready, out_valid, cout, ovf, zero;

    logic [7:0]  a8, b8, sum8;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8;

    logic [63:0] a64, b64, sum64;
    logic        in_ready64, out_valid64, cout64, ovf64, zero64;

    int checks = 0;
    int errors = 0;

    cla_pipe_addsub #(.N(32), .BLK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe_addsub #(.N(8), .BLK(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    cla_pipe_addsub #(.N(64), .BLK(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .a(a64), .b(b64), .cin(cin), .sub(sub),
        .out_valid(out_valid64), .out_ready(out_ready),
        .sum(sum64), .cout(cout64), .ovf(ovf64), .zero(zero64)
    );

    // Reference result: [63:0] sum, [64] cout, [65] ovf, [66] zero
    function automatic logic [66:0] ref_calc(input int unsigned w, input logic [63:0] x,
                                             input logic [63:0] y, input logic ci, input logic s);
        logic [63:0] mask, xx, be, sm;
        logic [64:0] full;
        logic        co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        xx   = x & mask;
        be   = (s ? ~y : y) & mask;
        full = {1'b0, xx} + {1'b0, be} + {64'd0, (s ? 1'b1 : ci)};
        sm   = full[63:0] & mask;
        co   = full[w];
        ov   = (xx[w-1] == be[w-1]) && (sm[w-1] != xx[w-1]);
        return {(sm == 64'd0), ov, co, sm};
    endfunction

    task automatic send_one(input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic s);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0)
            begin errors++; $display("FAIL reset_state: out_valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
                                     out_valid, sum, cout, ovf, zero); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_wrap;
        a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0)
            begin errors++; $display("FAIL add_wrap_early: out_valid=%b want 0 one cycle after accept", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h0 || cout !== 1'b1 || zero !== 1'b1 || ovf !== 1'b0)
            begin errors++; $display("FAIL add_wrap: v=%b sum=%h c=%b z=%b o=%b want v=1 sum=0 c=1 z=1 o=0",
                                     out_valid, sum, cout, zero, ovf); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0)
            begin errors++; $display("FAIL add_wrap_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_sub;
        send_one(32'h5, 32'h7, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'hFFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0)
            begin errors++; $display("FAIL sub_5_7: v=%b sum=%h c=%b o=%b z=%b want v=1 sum=fffffffe c=0 o=0 z=0",
                                     out_valid, sum, cout, ovf, zero); end
        send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h7FFF_FFFF || cout !== 1'b1 || ovf !== 1'b1)
            begin errors++; $display("FAIL sub_min_1: v=%b sum=%h c=%b o=%b want v=1 sum=7fffffff c=1 o=1",
                                     out_valid, sum, cout, ovf); end
        send_one(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h0 || cout !== 1'b1 || zero !== 1'b1 || ovf !== 1'b0)
            begin errors++; $display("FAIL sub_equal: v=%b sum=%h c=%b z=%b o=%b want v=1 sum=0 c=1 z=1 o=0",
                                     out_valid, sum, cout, zero, ovf); end
    endtask

    task automatic test_add_ovf;
        send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h8000_0000 || ovf !== 1'b1 || cout !== 1'b0 || zero !== 1'b0)
            begin errors++; $display("FAIL add_ovf: v=%b sum=%h o=%b c=%b z=%b want v=1 sum=80000000 o=1 c=0 z=0",
                                     out_valid, sum, ovf, cout, zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] va[4] = '{32'h1, 32'hA, 32'h100, 32'h0};
        logic [31:0] vb[4] = '{32'h2, 32'h3, 32'h1, 32'h1};
        logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es[4] = '{32'h3, 32'hE, 32'hFF, 32'hFFFF_FFFF};
        logic        ec[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t < 4) begin
                a = va[t]; b = vb[t]; cin = vc[t]; sub = vs[t]; in_valid = 1'b1;
                checks++;
                if (in_ready !== 1'b1)
                    begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (t >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== es[t-1] || cout !== ec[t-1])
                    begin errors++; $display("FAIL b2b_result[%0d]: v=%b sum=%h c=%b want v=1 sum=%h c=%b",
                                             t-1, out_valid, sum, cout, es[t-1], ec[t-1]); end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [66:0] q[$];
        logic [66:0] e;
        int          acc = 0;
        int          rcv = 0;
        logic        fi, fo, o_c, o_v, o_z;
        logic [31:0] o_s;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            out_ready = (cyc >= 6);
            if (acc < 5) begin
                in_valid = 1'b1;
                a   = 32'h1111_1111 * (acc + 1);
                b   = 32'(acc + 5);
                cin = acc[0];
                sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #3;
            if (cyc >= 2 && cyc <= 5) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== q[0][31:0])
                    begin errors++; $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b sum=%h want 0 1 %h",
                                             cyc, in_ready, out_valid, sum, q[0][31:0]); end
            end
            fi = in_valid & in_ready;
            fo = out_valid & out_ready;
            o_s = sum; o_c = cout; o_v = ovf; o_z = zero;
            @(posedge clk); #1;
            if (fo) begin
                e = q.pop_front();
                rcv++;
                checks++;
                if (o_s !== e[31:0] || o_c !== e[64] || o_v !== e[65] || o_z !== e[66])
                    begin errors++; $display("FAIL bp_result[%0d]: sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                                             rcv-1, o_s, o_c, o_v, o_z, e[31:0], e[64], e[65], e[66]); end
            end
            if (fi) begin
                q.push_back(ref_calc(32, {32'd0, a}, {32'd0, b}, cin, sub));
                acc++;
            end
            if (cyc == 5) begin
                checks++;
                if (acc != 2)
                    begin errors++; $display("FAIL bp_accepted: got %0d beats accepted under stall, want 2", acc); end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (rcv != 5)
            begin errors++; $display("FAIL bp_delivered: got %0d results want 5", rcv); end
        out_ready = 1'b1;
    endtask

    task automatic test_async_reset;
        logic seen;
        out_ready = 1'b0;
        a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h2; b = 32'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1)
            begin errors++; $display("FAIL arst_pre: out_valid=%b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_immediate: out_valid=%b sum=%h in_ready=%b want 0 0 1",
                                     out_valid, sum, in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_stale: stale_out=%b in_ready=%b want 0 1", seen, in_ready); end
    endtask

    task automatic test_random;
        localparam int NB = 400;
        logic [66:0] q32[$], q8[$], q64[$];
        logic [66:0] e;
        int          sent = 0, r32 = 0, r8 = 0, r64 = 0;
        logic        fi32, fi8, fi64, fo32, fo8, fo64;
        logic [31:0] s32;
        logic [7:0]  s8;
        logic [63:0] s64;
        logic [2:0]  f32, f8, f64;
        for (int cyc = 0; cyc < 5000 && (r32 < NB || r8 < NB || r64 < NB); cyc++) begin
            a   = $urandom;  b   = $urandom;
            a8  = 8'($urandom); b8 = 8'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            cin = 1'($urandom); sub = 1'($urandom);
            if (cyc % 97 == 5) begin
                a = 32'hFFFF_FFFF; b = 32'h0; a8 = 8'h7F; b8 = 8'h80; a64 = '1; b64 = '1;
            end
            in_valid  = (sent < NB) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            fi32 = in_valid & in_ready;   fo32 = out_valid & out_ready;
            fi8  = in_valid & in_ready8;  fo8  = out_valid8 & out_ready;
            fi64 = in_valid & in_ready64; fo64 = out_valid64 & out_ready;
            s32 = sum;   f32 = {zero, ovf, cout};
            s8  = sum8;  f8  = {zero8, ovf8, cout8};
            s64 = sum64; f64 = {zero64, ovf64, cout64};
            @(posedge clk); #1;
            if (fo32) begin
                checks++;
                if (q32.size() == 0) begin errors++; $display("FAIL rnd32_extra: unexpected result %h", s32); end
                else begin
                    e = q32.pop_front(); r32++;
                    if (s32 !== e[31:0] || f32 !== e[66:64])
                        begin errors++; $display("FAIL rnd32[%0d]: sum=%h zoc=%b want sum=%h zoc=%b",
                                                 r32-1, s32, f32, e[31:0], e[66:64]); end
                end
            end
            if (fo8) begin
                checks++;
                if (q8.size() == 0) begin errors++; $display("FAIL rnd8_extra: unexpected result %h", s8); end
                else begin
                    e = q8.pop_front(); r8++;
                    if (s8 !== e[7:0] || f8 !== e[66:64])
                        begin errors++; $display("FAIL rnd8[%0d]: sum=%h zoc=%b want sum=%h zoc=%b",
                                                 r8-1, s8, f8, e[7:0], e[66:64]); end
                end
            end
            if (fo64) begin
                checks++;
                if (q64.size() == 0) begin errors++; $display("FAIL rnd64_extra: unexpected result %h", s64); end
                else begin
                    e = q64.pop_front(); r64++;
                    if (s64 !== e[63:0] || f64 !== e[66:64])
                        begin errors++; $display("FAIL rnd64[%0d]: sum=%h zoc=%b want sum=%h zoc=%b",
                                                 r64-1, s64, f64, e[63:0], e[66:64]); end
                end
            end
            if (fi32) q32.push_back(ref_calc(32, {32'd0, a}, {32'd0, b}, cin, sub));
            if (fi8)  q8.push_back(ref_calc(8, {56'd0, a8}, {56'd0, b8}, cin, sub));
            if (fi64) q64.push_back(ref_calc(64, a64, b64, cin, sub));
            if (fi32) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (r32 != NB || r8 != NB || r64 != NB)
            begin errors++; $display("FAIL rnd_count: got %0d/%0d/%0d results want %0d each", r32, r8, r64, NB); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        a8 = '0; b8 = '0; a64 = '0; b64 = '0;
        test_reset;
        test_add_wrap;
        test_sub;
        test_add_ovf;
        test_back_to_back;
        test_backpressure;
        test_async_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
